// File: rtl/mem_lsu_stage_if.sv
// Data-bus bundle between the memory-stage LSU (master) and the data memory (slave).
// Request side is req/we/addr/be/wdata; response side is gnt/rvalid/rdata.
interface mem_lsu_stage_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [XLEN/8-1:0]     be;
  logic [XLEN-1:0]       wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [XLEN-1:0]       rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_lsu_stage.sv
// Memory-stage load/store unit: drives a req/gnt/rvalid bus, builds byte enables,
// extends loads, drops misaligned accesses and bounds each access with a watchdog.
module mem_lsu_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_i,
  input  logic                   MemRead_i,
  input  logic                   MemWrite_i,
  input  logic [2:0]             funct3_i,
  input  logic [XLEN-1:0]        ALUResult_i,
  input  logic [XLEN-1:0]        WriteData_i,
  input  logic [4:0]             Rd_i,
  input  logic                   RegWrite_i,
  mem_lsu_stage_if.master        mem,
  output logic [XLEN-1:0]        load_data_o,
  output logic                   RegWrite_o,
  output logic [4:0]             RdM_o,
  output logic                   RegWriteM_o,
  output logic                   stall_o,
  output logic                   misalign_o,
  output logic                   bus_err_o
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            op, is_load, is_store, mis, access, done, timeout;
  logic            size_h, size_w;
  logic [1:0]      off;
  logic [XLEN-1:0] lane, ext;

  assign off      = ALUResult_i[1:0];
  assign size_h   = (funct3_i[1:0] == 2'b01);
  assign size_w   = funct3_i[1];
  assign op       = valid_i & (MemRead_i | MemWrite_i);
  assign is_load  = op & MemRead_i;
  assign is_store = op & MemWrite_i;
  assign mis      = op & ((size_h & off[0]) | (size_w & (off != 2'b00)));
  assign access   = op & ~mis;

  always_comb begin
    done = 1'b0;
    case (state_q)
      StIdle, StReq: done = access & mem.gnt & (is_store | mem.rvalid);
      StWait:        done = access & mem.rvalid;
      default:       done = 1'b0;
    endcase
  end

  // cnt_q is 0 in IDLE and counts cycles already spent on the access otherwise.
  assign timeout = (TIMEOUT != 0) & access & ~done & (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (access && !done && !timeout) begin
          state_d = mem.gnt ? StWait : StReq;
          cnt_d   = CntW'(1);
        end
      end
      StReq: begin
        if (done || timeout || !access) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (mem.gnt) state_d = StWait;
        end
      end
      StWait: begin
        if (done || timeout || !access) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lane = mem.rdata >> {off, 3'b000};

  always_comb begin
    case (funct3_i)
      3'b000:  ext = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'b001:  ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b100:  ext = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  ext = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: ext = lane;
    endcase
  end

  always_comb begin
    case (funct3_i[1:0])
      2'b00: begin
        mem.be    = NB'(1) << off;
        mem.wdata = {NB{WriteData_i[7:0]}};
      end
      2'b01: begin
        mem.be    = NB'(3) << off;
        mem.wdata = {(NB/2){WriteData_i[15:0]}};
      end
      default: begin
        mem.be    = '1;
        mem.wdata = WriteData_i;
      end
    endcase
  end

  // Request is issued combinationally from IDLE and held through REQ; never in WAIT.
  assign mem.req     = ~reset & access & (state_q != StWait);
  assign mem.we      = MemWrite_i;
  assign mem.addr    = {ALUResult_i[ADDR_WIDTH-1:2], 2'b00};

  assign load_data_o = (~reset & done & is_load) ? ext : '0;
  assign RegWrite_o  = ~reset & RegWrite_i & ~mis & ~timeout;
  assign RegWriteM_o = RegWrite_o;
  assign RdM_o       = Rd_i;
  assign stall_o     = ~reset & access & ~done & ~timeout;
  assign misalign_o  = ~reset & mis;
  assign bus_err_o   = ~reset & timeout;

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Self-checking bench for mem_lsu_stage: scoreboarded bus accesses plus misalign,
// pass-through, watchdog (TIMEOUT=4 instance) and reset-abandon scenarios.
module tb_mem_lsu_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, valid, mread, mwrite, rw_i;
  logic [2:0]  f3;
  logic [31:0] alu, wd;
  logic [4:0]  rd;
  logic        gnt, rvalid;
  logic [31:0] rdata;

  logic [31:0] ld, ld_t;
  logic        rw_o, rw_o_t, rwm, rwm_t, stall, stall_t, mis, mis_t, berr, berr_t;
  logic [4:0]  rdm, rdm_t;

  mem_lsu_stage_if #(.XLEN(32), .ADDR_WIDTH(32)) bus ();
  mem_lsu_stage_if #(.XLEN(32), .ADDR_WIDTH(32)) bus_t ();

  assign bus.gnt      = gnt;
  assign bus.rvalid   = rvalid;
  assign bus.rdata    = rdata;
  assign bus_t.gnt    = gnt;
  assign bus_t.rvalid = rvalid;
  assign bus_t.rdata  = rdata;

  mem_lsu_stage #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .valid_i(valid), .MemRead_i(mread), .MemWrite_i(mwrite),
    .funct3_i(f3), .ALUResult_i(alu), .WriteData_i(wd), .Rd_i(rd), .RegWrite_i(rw_i),
    .mem(bus.master), .load_data_o(ld), .RegWrite_o(rw_o), .RdM_o(rdm),
    .RegWriteM_o(rwm), .stall_o(stall), .misalign_o(mis), .bus_err_o(berr)
  );

  mem_lsu_stage #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset), .valid_i(valid), .MemRead_i(mread), .MemWrite_i(mwrite),
    .funct3_i(f3), .ALUResult_i(alu), .WriteData_i(wd), .Rd_i(rd), .RegWrite_i(rw_i),
    .mem(bus_t.master), .load_data_o(ld_t), .RegWrite_o(rw_o_t), .RdM_o(rdm_t),
    .RegWriteM_o(rwm_t), .stall_o(stall_t), .misalign_o(mis_t), .bus_err_o(berr_t)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        rw;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic drive_op(input logic r, input logic w, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d, input logic rwi);
    valid = 1'b1; mread = r; mwrite = w; f3 = f; alu = a; wd = d; rw_i = rwi; rd = 5'd7;
  endtask

  task automatic drive_nop();
    valid = 1'b0; mread = 1'b0; mwrite = 1'b0; rw_i = 1'b0; gnt = 1'b0; rvalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_nop();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One access with gnt at cycle gd and (loads) rvalid at cycle rvd, counted from issue.
  task automatic run_access(input string name, input logic r, input logic w,
                            input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] rdat, input int gd, input int rvd,
                            input logic [3:0] ebe, input logic [31:0] ewd,
                            input logic [31:0] edata, input logic erw);
    int   done_k;
    bit   finished;
    exp_t e;
    done_k   = w ? gd : rvd;
    finished = 1'b0;
    e.data   = edata;
    e.rw     = erw;
    sb_q.push_back(e);
    @(negedge clk);
    drive_op(r, w, f, a, d, erw);
    rdata = rdat;
    for (int k = 0; k < 20 && !finished; k++) begin
      if (k > 0) @(negedge clk);
      gnt    = (k == gd);
      rvalid = r && (k == rvd);
      #1;
      if (k == 0) begin
        checks++;
        if (bus.be !== ebe) begin
          errors++; $display("FAIL %s be got %b exp %b", name, bus.be, ebe);
        end
        checks++;
        if (bus.addr !== (a & 32'hFFFF_FFFC)) begin
          errors++; $display("FAIL %s addr got %h exp %h", name, bus.addr, a & 32'hFFFF_FFFC);
        end
        if (w) begin
          checks++;
          if (bus.wdata !== ewd) begin
            errors++; $display("FAIL %s wdata got %h exp %h", name, bus.wdata, ewd);
          end
        end
      end
      checks++;
      if (bus.req !== (k <= gd)) begin
        errors++; $display("FAIL %s req k=%0d got %b exp %b", name, k, bus.req, k <= gd);
      end
      checks++;
      if (stall !== (k != done_k)) begin
        errors++; $display("FAIL %s stall k=%0d got %b exp %b", name, k, stall, k != done_k);
      end
      if (stall === 1'b0) begin
        e = sb_q.pop_front();
        checks++;
        if (ld !== e.data) begin
          errors++; $display("FAIL %s load_data got %h exp %h", name, ld, e.data);
        end
        checks++;
        if (rw_o !== e.rw) begin
          errors++; $display("FAIL %s RegWrite_o got %b exp %b", name, rw_o, e.rw);
        end
        finished = 1'b1;
      end
    end
    if (!finished) begin
      checks++; errors++;
      $display("FAIL %s no completion within cycle budget", name);
      void'(sb_q.pop_front());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_op(1'b0, 1'b1, 3'b010, 32'h100, 32'h1234_5678, 1'b1);
    gnt = 1'b1;
    #1;
    checks++;
    if (bus.req !== 1'b0 || stall !== 1'b0 || rw_o !== 1'b0 || ld !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs req=%b stall=%b rw=%b ld=%h exp 0 0 0 0",
               bus.req, stall, rw_o, ld);
    end
    @(negedge clk);
    alu = 32'h42;
    #1;
    checks++;
    if (mis !== 1'b0 || berr !== 1'b0) begin
      errors++; $display("FAIL reset_pulses misalign=%b bus_err=%b exp 0 0", mis, berr);
    end
    @(negedge clk);
    reset = 1'b0;
    drive_nop();
  endtask

  task automatic test_store();
    run_access("sb_0x103", 1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0, 0, 0,
               4'b1000, 32'hA5A5_A5A5, 32'h0, 1'b0);
    run_access("sh_0x002", 1'b0, 1'b1, 3'b001, 32'h002, 32'h1234_BEEF, 32'h0, 0, 0,
               4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0);
    run_access("sw_gnt1", 1'b0, 1'b1, 3'b010, 32'h010, 32'hCAFE_F00D, 32'h0, 1, 1,
               4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0);
  endtask

  task automatic test_load_extend();
    run_access("lh_0x202", 1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 32'h8001_0000, 0, 0,
               4'b1100, 32'h0, 32'hFFFF_8001, 1'b1);
    run_access("lhu_0x202", 1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 32'h8001_0000, 0, 0,
               4'b1100, 32'h0, 32'h0000_8001, 1'b1);
    run_access("lb_0x201", 1'b1, 1'b0, 3'b000, 32'h201, 32'h0, 32'h0000_8000, 0, 0,
               4'b0010, 32'h0, 32'hFFFF_FF80, 1'b1);
    run_access("lbu_0x201", 1'b1, 1'b0, 3'b100, 32'h201, 32'h0, 32'h0000_8000, 0, 0,
               4'b0010, 32'h0, 32'h0000_0080, 1'b1);
  endtask

  task automatic test_wait_latency();
    run_access("lw_gnt2_rv5", 1'b1, 1'b0, 3'b010, 32'h040, 32'h0, 32'hDEAD_BEEF, 2, 5,
               4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b1);
    run_access("lw_gnt0_rv2", 1'b1, 1'b0, 3'b010, 32'h044, 32'h0, 32'h1357_9BDF, 0, 2,
               4'b1111, 32'h0, 32'h1357_9BDF, 1'b1);
  endtask

  task automatic test_misalign();
    @(negedge clk);
    drive_op(1'b0, 1'b1, 3'b010, 32'h042, 32'h0, 1'b1);
    gnt = 1'b1;
    #1;
    checks++;
    if (mis !== 1'b1 || bus.req !== 1'b0 || rw_o !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL sw_misalign mis=%b req=%b rw=%b stall=%b exp 1 0 0 0",
               mis, bus.req, rw_o, stall);
    end
    @(negedge clk);
    drive_op(1'b1, 1'b0, 3'b001, 32'h201, 32'h0, 1'b1);
    #1;
    checks++;
    if (mis !== 1'b1 || bus.req !== 1'b0 || rw_o !== 1'b0) begin
      errors++; $display("FAIL lh_misalign mis=%b req=%b rw=%b exp 1 0 0", mis, bus.req, rw_o);
    end
    @(negedge clk);
    drive_nop();
    #1;
    checks++;
    if (mis !== 1'b0) begin
      errors++; $display("FAIL misalign_pulse got %b exp 0", mis);
    end
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    valid = 1'b1; mread = 1'b0; mwrite = 1'b0; rw_i = 1'b1; rd = 5'd9;
    rvalid = 1'b1; gnt = 1'b1; rdata = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (rw_o !== 1'b1 || rwm !== 1'b1 || rdm !== 5'd9 || rdm_t !== 5'd9) begin
      errors++;
      $display("FAIL passthru_rw rw=%b rwm=%b rd=%0d rd_t=%0d exp 1 1 9 9",
               rw_o, rwm, rdm, rdm_t);
    end
    checks++;
    if (stall !== 1'b0 || ld !== 32'h0 || bus.req !== 1'b0) begin
      errors++;
      $display("FAIL passthru_idle stall=%b ld=%h req=%b exp 0 0 0", stall, ld, bus.req);
    end
    @(negedge clk);
    drive_nop();
  endtask

  task automatic test_timeout();
    do_reset();
    @(negedge clk);
    drive_op(1'b1, 1'b0, 3'b010, 32'h080, 32'h0, 1'b1);
    rdata = 32'h7777_0001;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (stall_t !== (k < 3) || berr_t !== (k == 3)) begin
        errors++;
        $display("FAIL timeout k=%0d stall=%b bus_err=%b exp %b %b",
                 k, stall_t, berr_t, k < 3, k == 3);
      end
    end
    checks++;
    if (rw_o_t !== 1'b0 || rwm_t !== 1'b0 || ld_t !== 32'h0 || mis_t !== 1'b0) begin
      errors++;
      $display("FAIL timeout_outputs rw=%b rwm=%b ld=%h mis=%b exp 0 0 0 0",
               rw_o_t, rwm_t, ld_t, mis_t);
    end
    @(negedge clk);
    drive_nop();
    rvalid = 1'b1;
    #1;
    checks++;
    if (ld_t !== 32'h0 || stall_t !== 1'b0 || berr_t !== 1'b0) begin
      errors++;
      $display("FAIL stray_rvalid ld=%h stall=%b bus_err=%b exp 0 0 0", ld_t, stall_t, berr_t);
    end
    @(negedge clk);
    drive_op(1'b1, 1'b0, 3'b010, 32'h084, 32'h0, 1'b1);
    rvalid = 1'b1;
    #1;
    checks++;
    if (stall_t !== 1'b1 || bus_t.req !== 1'b1) begin
      errors++;
      $display("FAIL rvalid_no_gnt stall=%b req=%b exp 1 1", stall_t, bus_t.req);
    end
    @(negedge clk);
    gnt = 1'b1;
    #1;
    checks++;
    if (stall_t !== 1'b0 || ld_t !== 32'h7777_0001) begin
      errors++;
      $display("FAIL after_timeout_load stall=%b ld=%h exp 0 77770001", stall_t, ld_t);
    end
    do_reset();
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    drive_op(1'b1, 1'b0, 3'b010, 32'h044, 32'h0, 1'b1);
    gnt = 1'b1;
    rdata = 32'h0000_F000;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL wait_enter stall got %b exp 1", stall);
    end
    @(negedge clk);
    gnt = 1'b0;
    #1;
    checks++;
    if (bus.req !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL wait_state req=%b stall=%b exp 0 1", bus.req, stall);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || bus.req !== 1'b0) begin
      errors++; $display("FAIL reset_in_wait stall=%b req=%b exp 0 0", stall, bus.req);
    end
    @(negedge clk);
    reset = 1'b0;
    drive_nop();
    rvalid = 1'b1;
    #1;
    checks++;
    if (ld !== 32'h0 || stall !== 1'b0) begin
      errors++; $display("FAIL post_reset_rvalid ld=%h stall=%b exp 0 0", ld, stall);
    end
    @(negedge clk);
    drive_op(1'b1, 1'b0, 3'b000, 32'h045, 32'h0, 1'b1);
    rvalid = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1 || bus.req !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle stall=%b req=%b exp 1 1", stall, bus.req);
    end
    @(negedge clk);
    gnt = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || ld !== 32'hFFFF_FFF0) begin
      errors++; $display("FAIL post_reset_lb stall=%b ld=%h exp 0 fffffff0", stall, ld);
    end
    @(negedge clk);
    drive_nop();
  endtask

  initial begin
    reset = 1'b1;
    drive_nop();
    f3 = 3'b000; alu = '0; wd = '0; rd = '0; rdata = '0;
    test_reset();
    test_store();
    test_load_extend();
    test_wait_latency();
    test_misalign();
    test_passthrough();
    test_timeout();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "time limit");
  end

endmodule
